multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle control FSM for the 8-bit accumulator MIPS datapath.
- Decodes the instruction register opcode and sequences fetch, decode, memory and execute steps.
- Drives ALUOp plus all register-enable and mux-select lines to the datapath.
- Waits on a memory-ready handshake and flags a memory timeout.

Parameters:
- WAIT_LIMIT, 0, max consecutive cycles a memory state may wait for MemReady; 0 means wait forever.
- CNT_W, 16, width of the instruction counter (used only when the optional feature is compiled in).

Ports:
- clk  input  1  clock, all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- Opcode  input  3  IR[7:5]; registered IR from the datapath.
- Zero  input  1  accumulator-equals-zero flag.
- MemReady  input  1  memory completes the current access this cycle.
- ALUOp  output  2  00 add, 01 sub, 10 and, 11 not.
- ALUSrcA  output  1  0 = PC, 1 = ACC.
- ALUSrcB  output  2  00 = MDR, 01 = constant 1, 10 = zero.
- IorD  output  1  memory address select: 0 = PC, 1 = IR[4:0].
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load IR.
- MDRWrite  output  1  load MDR.
- ACCWrite  output  1  load accumulator.
- ACCSrc  output  1  0 = MDR, 1 = ALU result.
- PCLoad  output  1  load PC; already qualified with Zero for JZ.
- PCSrc  output  1  0 = ALU result, 1 = IR[4:0] zero-extended.
- MemError  output  1  sticky timeout flag.

Behaviour:
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 AND, 101 NOT, 110 JMP, 111 JZ.
- Reset:
  - State goes to RESET.
  - All outputs are 0, including MemError; wait counter is 0.
  - RESET moves to FETCH on the next edge unconditionally.
- Outputs not listed for a state are 0. All outputs are combinational from state, Opcode, Zero and MemReady.
- FETCH:
  - MemRead=1, IorD=0.
  - Hold FETCH while MemReady=0.
  - On the MemReady=1 cycle, also assert IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCLoad=1, PCSrc=0.
  - Then go to DECODE.
- DECODE: no asserted outputs. Next state by Opcode:
  - LOAD, ADD, SUB, AND → MEMRD.
  - STORE → MEMWR.
  - NOT → NOTEX.
  - JMP → JMP.
  - JZ → JZ.
- MEMRD:
  - MemRead=1, IorD=1; hold while MemReady=0.
  - On the ready cycle, MDRWrite=1, then go to LOADWB (LOAD) or ALUWB (ADD/SUB/AND).
- MEMWR: MemWrite=1, IorD=1; hold while MemReady=0; on the ready cycle go to FETCH.
- LOADWB: ACCWrite=1, ACCSrc=0 → FETCH.
- ALUWB:
  - ALUSrcA=1, ALUSrcB=00, ACCWrite=1, ACCSrc=1 → FETCH.
  - ALUOp = 00 for ADD, 01 for SUB, 10 for AND.
- NOTEX: ALUSrcA=1, ALUOp=11, ACCWrite=1, ACCSrc=1 → FETCH.
- JMP: PCLoad=1, PCSrc=1 → FETCH.
- JZ: PCLoad=Zero, PCSrc=1 → FETCH. Zero is sampled in the JZ cycle.
- Instruction latency, including FETCH and DECODE, with zero wait states:
  - LOAD and ALU ops: 4 cycles.
  - STORE: 3 cycles.
  - NOT, JMP, JZ: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Wait counter:
  - Increments each cycle in FETCH/MEMRD/MEMWR with MemReady=0.
  - Clears on MemReady=1 and on leaving the state.
- Timeout:
  - When WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT while MemReady is still 0, set MemError=1 and go to HALT.
  - HALT: all outputs 0 except MemError. Only rst exits HALT.
- MemReady is ignored outside the memory states.
- Reset asserted mid-instruction: immediate return to RESET, outputs forced 0 within the same cycle, no partial write enables.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- When defined:
  - Adds output InstrCount (CNT_W bits), reset to 0.
  - Increments by 1 on every transition into FETCH from any state other than RESET.
  - Wraps from all-ones to 0.
  - Stops counting in HALT.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- rst pulse mid-ALUWB with MemReady=1 → all outputs 0 immediately; RESET for one cycle, then FETCH with MemRead=1, IorD=0.
- Opcode=010 with MemReady always 1 → over 4 cycles: FETCH (IRWrite=1, PCLoad=1), DECODE, MEMRD (MDRWrite=1, IorD=1), ALUWB (ALUOp=00, ACCWrite=1, ACCSrc=1); back in FETCH on cycle 5.
- Opcode=001 with MemReady low for 3 cycles in MEMWR → MemWrite=1 and IorD=1 held for 4 cycles; FETCH follows the ready cycle; no ACCWrite at any point.
- Opcode=111: Zero=1 → PCLoad=1, PCSrc=1 in the JZ cycle. Repeat with Zero=0 → PCLoad=0, and the next state is still FETCH.
- WAIT_LIMIT=4, MemReady stuck at 0 in FETCH → MemError=1 after 4 wait cycles; HALT with all other outputs 0; stays in HALT until rst.
- INSTR_COUNT_EN defined, CNT_W=4, program of 17 NOT instructions → InstrCount wraps to 1.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle control FSM for the 8-bit accumulator datapath (optional INSTR_COUNT_EN instruction counter)
module multicycle_controller #(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MDRWrite,
    output logic             ACCWrite,
    output logic             ACCSrc,
    output logic             PCLoad,
    output logic             PCSrc,
`ifdef INSTR_COUNT_EN
    output logic [CNT_W-1:0] InstrCount,
`endif
    output logic             MemError
);

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMRD,
        S_MEMWR,
        S_LOADWB,
        S_ALUWB,
        S_NOTEX,
        S_JMP,
        S_JZ,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZ    = 3'b111;

    // The counter only needs to reach WAIT_LIMIT-1: the cycle that would
    // make it WAIT_LIMIT goes to HALT instead.
    localparam int unsigned WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_wait;
    logic              wait_hit;

    assign wait_hit = (WAIT_LIMIT != 0) && (wait_cnt_q == WAIT_LAST);

    // State and wait-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RESET;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state decode and datapath control outputs
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        mem_wait   = 1'b0;
        ALUOp      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MDRWrite   = 1'b0;
        ACCWrite   = 1'b0;
        ACCSrc     = 1'b0;
        PCLoad     = 1'b0;
        PCSrc      = 1'b0;
        MemError   = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    // PC <= PC + 1 in the same cycle the IR is loaded
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCLoad  = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_DECODE: begin
                case (Opcode)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND: state_d = S_MEMRD;
                    OP_STORE: state_d = S_MEMWR;
                    OP_NOT:   state_d = S_NOTEX;
                    OP_JMP:   state_d = S_JMP;
                    OP_JZ:    state_d = S_JZ;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) begin
                    MDRWrite = 1'b1;
                    state_d  = (Opcode == OP_LOAD) ? S_LOADWB : S_ALUWB;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) state_d = S_FETCH;
                else          mem_wait = 1'b1;
            end
            S_LOADWB: begin
                ACCWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_ALUWB: begin
                ALUSrcA  = 1'b1;
                ACCWrite = 1'b1;
                ACCSrc   = 1'b1;
                case (Opcode)
                    OP_SUB:  ALUOp = 2'b01;
                    OP_AND:  ALUOp = 2'b10;
                    default: ALUOp = 2'b00;
                endcase
                state_d = S_FETCH;
            end
            S_NOTEX: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b11;
                ACCWrite = 1'b1;
                ACCSrc   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JMP: begin
                PCLoad  = 1'b1;
                PCSrc   = 1'b1;
                state_d = S_FETCH;
            end
            S_JZ: begin
                PCLoad  = Zero;
                PCSrc   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: MemError = 1'b1;
            default: state_d = S_RESET;
        endcase

        // A stalled memory access either times out or keeps counting
        if (mem_wait) begin
            if (wait_hit) state_d = S_HALT;
            else          wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

`ifdef INSTR_COUNT_EN
    logic [CNT_W-1:0] instr_cnt_q;

    assign InstrCount = instr_cnt_q;

    // Count completed instructions: every return to FETCH except the one out of RESET
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= '0;
        end else if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_RESET)) begin
            instr_cnt_q <= instr_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    typedef logic [14:0] exp_t;

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic       rdy;
        exp_t       e;
    } vec_t;

    // {ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, MDRWrite, ACCWrite, ACCSrc, PCLoad, PCSrc, MemError}
    localparam exp_t E_ZERO = 15'b00_0_00_0_0_0_0_0_0_0_0_0_0;
    localparam exp_t E_FW   = 15'b00_0_00_0_1_0_0_0_0_0_0_0_0;
    localparam exp_t E_FR   = 15'b00_0_01_0_1_0_1_0_0_0_1_0_0;
    localparam exp_t E_MRW  = 15'b00_0_00_1_1_0_0_0_0_0_0_0_0;
    localparam exp_t E_MRR  = 15'b00_0_00_1_1_0_0_1_0_0_0_0_0;
    localparam exp_t E_MW   = 15'b00_0_00_1_0_1_0_0_0_0_0_0_0;
    localparam exp_t E_LWB  = 15'b00_0_00_0_0_0_0_0_1_0_0_0_0;
    localparam exp_t E_ADD  = 15'b00_1_00_0_0_0_0_0_1_1_0_0_0;
    localparam exp_t E_SUB  = 15'b01_1_00_0_0_0_0_0_1_1_0_0_0;
    localparam exp_t E_AND  = 15'b10_1_00_0_0_0_0_0_1_1_0_0_0;
    localparam exp_t E_NOT  = 15'b11_1_00_0_0_0_0_0_1_1_0_0_0;
    localparam exp_t E_JMP  = 15'b00_0_00_0_0_0_0_0_0_0_1_1_0;
    localparam exp_t E_JZ0  = 15'b00_0_00_0_0_0_0_0_0_0_0_1_0;
    localparam exp_t E_HALT = 15'b00_0_00_0_0_0_0_0_0_0_0_0_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD, MemRead, MemWrite, IRWrite, MDRWrite;
    logic       ACCWrite, ACCSrc, PCLoad, PCSrc, MemError;
`ifdef INSTR_COUNT_EN
    logic [3:0] InstrCount;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    exp_t  exp_q[$];
    string name_q[$];

    vec_t vecs[64];
    int   nvec = 0;

    always #5 clk = ~clk;

    multicycle_controller #(
        .WAIT_LIMIT(4),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Opcode    (Opcode),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .MDRWrite  (MDRWrite),
        .ACCWrite  (ACCWrite),
        .ACCSrc    (ACCSrc),
        .PCLoad    (PCLoad),
        .PCSrc     (PCSrc),
`ifdef INSTR_COUNT_EN
        .InstrCount(InstrCount),
`endif
        .MemError  (MemError)
    );

    function automatic exp_t actual();
        return {ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                MDRWrite, ACCWrite, ACCSrc, PCLoad, PCSrc, MemError};
    endfunction

    task automatic check_now(input exp_t e, input string name);
        exp_t a;
        a = actual();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: outputs got %b want %b", name, a, e);
        end
    endtask

    // Scoreboard side: compare the oldest pending expectation mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check_now(e, nm);
        end
    end

    // Called just after a rising edge: drive one cycle of inputs, queue its expectation
    task automatic step(input logic [2:0] op, input logic z, input logic rdy,
                        input exp_t e, input string name);
        Opcode   = op;
        Zero     = z;
        MemReady = rdy;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [2:0] op, input logic z, input logic rdy, input exp_t e);
        vecs[nvec].op  = op;
        vecs[nvec].z   = z;
        vecs[nvec].rdy = rdy;
        vecs[nvec].e   = e;
        nvec++;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ADD, MemReady ignored in DECODE and ALUWB
        add(3'b010, 0, 1, E_FR);  add(3'b010, 0, 0, E_ZERO); add(3'b010, 0, 1, E_MRR); add(3'b010, 0, 0, E_ADD);
        // LOAD
        add(3'b000, 0, 1, E_FR);  add(3'b000, 0, 1, E_ZERO); add(3'b000, 0, 1, E_MRR); add(3'b000, 0, 1, E_LWB);
        // SUB with one MEMRD wait
        add(3'b011, 0, 1, E_FR);  add(3'b011, 0, 1, E_ZERO); add(3'b011, 0, 0, E_MRW); add(3'b011, 0, 1, E_MRR);
        add(3'b011, 0, 1, E_SUB);
        // AND with one FETCH wait
        add(3'b100, 0, 0, E_FW);  add(3'b100, 0, 1, E_FR);   add(3'b100, 0, 1, E_ZERO); add(3'b100, 0, 1, E_MRR);
        add(3'b100, 0, 1, E_AND);
        // STORE with three MEMWR waits
        add(3'b001, 0, 1, E_FR);  add(3'b001, 0, 1, E_ZERO); add(3'b001, 0, 0, E_MW);   add(3'b001, 0, 0, E_MW);
        add(3'b001, 0, 0, E_MW);  add(3'b001, 0, 1, E_MW);
        // JMP
        add(3'b110, 0, 1, E_FR);  add(3'b110, 0, 1, E_ZERO); add(3'b110, 1, 1, E_JMP);
        // JZ taken, then not taken
        add(3'b111, 0, 1, E_FR);  add(3'b111, 0, 1, E_ZERO); add(3'b111, 1, 1, E_JMP);
        add(3'b111, 1, 1, E_FR);  add(3'b111, 1, 1, E_ZERO); add(3'b111, 0, 1, E_JZ0);
        // NOT proves the JZ=0 path still returns to FETCH
        add(3'b101, 0, 1, E_FR);  add(3'b101, 0, 1, E_ZERO); add(3'b101, 0, 1, E_NOT);

        rst      = 1'b1;
        Opcode   = 3'b000;
        Zero     = 1'b0;
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_now(E_ZERO, "reset_held");
        rst = 1'b0;
        step(3'b000, 0, 1, E_ZERO, "reset_state");

        for (int i = 0; i < 17; i++) begin
            step(3'b101, 0, 1, E_FR,   $sformatf("not%0d_fetch", i));
            step(3'b101, 0, 1, E_ZERO, $sformatf("not%0d_decode", i));
            step(3'b101, 0, 1, E_NOT,  $sformatf("not%0d_exec", i));
        end
`ifdef INSTR_COUNT_EN
        n_cmp++;
        if (InstrCount !== 4'd1) begin
            n_bad++;
            $display("FAIL instr_count_wrap: got %0d want 1", InstrCount);
        end
`endif

        for (int i = 0; i < nvec; i++) begin
            step(vecs[i].op, vecs[i].z, vecs[i].rdy, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Memory timeout in FETCH: four wait cycles, then sticky HALT
        for (int i = 0; i < 4; i++) step(3'b000, 0, 0, E_FW, $sformatf("timeout_wait%0d", i));
        for (int i = 0; i < 3; i++) step(3'($urandom_range(7)), 1, 1, E_HALT, $sformatf("halt%0d", i));

        // Only reset leaves HALT
        rst = 1'b1;
        #1;
        check_now(E_ZERO, "halt_rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3'b010, 0, 1, E_ZERO, "halt_reset_cycle");

        // Reset in the middle of ALUWB with MemReady high
        step(3'b010, 0, 1, E_FR,   "mid_fetch");
        step(3'b010, 0, 1, E_ZERO, "mid_decode");
        step(3'b010, 0, 1, E_MRR,  "mid_memrd");
        #1;
        check_now(E_ADD, "mid_aluwb");
        #1;
        rst = 1'b1;
        #1;
        check_now(E_ZERO, "mid_aluwb_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3'b010, 0, 1, E_ZERO, "mid_reset_cycle");
        step(3'b010, 0, 0, E_FW,   "mid_fetch_after");

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
